control_ordenamiento: RTL and testbench
=======================================

// Module: control_ordenamiento
// PURPOSE
//  Sequencer for the load/sort/display datapath: captures N operands one per key strobe into an internal bank.
//  Sorts them in place by time-sharing a single compare-swap unit (bubble sort, one compare per cycle).
//  Then presents one sorted value at a time, stepped by a second strobe; the output feeds the BIN2BCD/7-seg path.
// PARAMETERS
//  N  8  number of operands held in the bank (>=2)
//  W  8  operand width in bits
// PORTS
//  reloj      in   1          system clock, all state on rising edge
//  reset      in   1          synchronous, active-high
//  entrada    in   W          operand to load (switches)
//  cargar     in   1          load strobe, level, already synchronised; rising edge detected internally
//  siguiente  in   1          display-advance strobe, level, synchronised; rising edge detected internally
//  salida     out  W          value currently displayed
//  indice     out  clog2(N)   position of salida within sorted bank
//  cantidad   out  clog2(N)+1 operands loaded so far (0..N)
//  ocupado    out  1          high while sorting
//  listo      out  1          high while in MUESTRA
// BEHAVIOUR
//  Reset: bank all 0, estado=CARGA, ptr=0, i=0, pasada=0, indice=0, cantidad=0, salida=0, ocupado=0, listo=0.
//  Edge detect: cargar_q/siguiente_q registered; pulse = x & ~x_q. Both _q regs reset to 1 (held key at reset != edge).
//  States (2-bit):
//  - CARGA: on cargar pulse: bank[ptr]<=entrada, ptr++, cantidad++ same edge. When write hits ptr==N-1 -> ORDENA next cycle; i=0, pasada=0, swapflag=0.
//  - ORDENA: each cycle compare bank[i], bank[i+1] via comp_intercambio; write swapped pair same edge; swapflag|=swap.
//    i==N-2 ends pass: if (no swap in pass incl. this compare) or pasada==N-2 -> MUESTRA, indice=0; else i=0, pasada++, swapflag=0.
//    Latency, last load to listo: best N-1 cycles (presorted), worst (N-1)^2 cycles (N=8: 7..49).
//  - MUESTRA: on siguiente pulse indice++, wrapping N-1 -> 0. cargar pulse -> CARGA, consumed as first load.
//    First load: bank[0]<=entrada, ptr=1, cantidad=1, indice=0.
//  Outputs: salida = bank[indice] when listo, else 0 (combinational from regs). ocupado=(estado==ORDENA). listo=(estado==MUESTRA).
//  Ignored events: cargar outside CARGA/MUESTRA; siguiente outside MUESTRA; simultaneous pulses in MUESTRA -> cargar wins.
//  Equal values: never swapped (stable). Reset mid-sort: full reset, partial results discarded.
//  Unused encoding 2'b11 -> CARGA next cycle with reset values.
// CONFIGURATION
//  ORDEN_DESCENDENTE_EN defined: swap when bank[i] < bank[i+1] (result descending, indice 0 = max).
//  Undefined (default): swap when bank[i] > bank[i+1] (ascending, indice 0 = min). Timing identical.
// STRUCTURE
//  Package ordenamiento_pkg: state encodings CARGA=0, ORDENA=1, MUESTRA=2; default N and W.
//  Sub-module comp_intercambio: combinational, in a,b[W]; out lo,hi[W], swap. Holds the macro-selected compare.
//  Top holds FSM, edge detectors, pointers and the N x W bank.
// TESTING
//  1) Load 5,3,8,1,9,2,7,4 (N=8,W=8), step siguiente x8 -> 1,2,3,4,5,7,8,9; listo after <=49 cycles.
//  2) Load presorted 0..7 -> ocupado high exactly 7 cycles, output 0..7.
//  3) Load 8x 0xAA -> one pass, 7 cycles, no swaps, all outputs 0xAA. Also 255,0 mix -> no width overflow.
//  4) Hold cargar high through reset release -> no load (cantidad=0); reset asserted mid-ORDENA -> CARGA, all zero.
//  5) In MUESTRA: 9 siguiente pulses -> indice wraps 7->0->1. Same-cycle cargar+siguiente -> CARGA, cantidad=1, bank[0]=entrada.
//  6) With ORDEN_DESCENDENTE_EN, vector of test 1 -> 9,8,7,5,4,3,2,1.

Source files
------------

// File: rtl/ordenamiento_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ordenamiento_pkg
//  Description : Shared constants for the load/sort/display sequencer:
//                default bank geometry and the 2-bit state encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package ordenamiento_pkg;

    // Default bank geometry
    localparam int c_n_default = 8;
    localparam int c_w_default = 8;

    // Sequencer state encodings (2'b11 is unused and recovers to c_carga)
    localparam logic [1:0] c_carga    = 2'd0;
    localparam logic [1:0] c_ordena   = 2'd1;
    localparam logic [1:0] c_muestra  = 2'd2;
    localparam logic [1:0] c_invalido = 2'd3;

endpackage : ordenamiento_pkg
`default_nettype wire

// File: rtl/comp_intercambio.sv
`default_nettype none
// ============================================================================
//  Module      : comp_intercambio
//  Description : Combinational compare-swap cell. 'lo' is the value that
//                belongs in the lower bank position, 'hi' the one for the
//                next position; 'swap' flags that the pair was out of order.
//                Sort direction is chosen by macro ORDEN_DESCENDENTE_EN
//                (defined: descending, undefined: ascending).
//  Revision    : 1.0 - initial release
// ============================================================================
module comp_intercambio
    import ordenamiento_pkg::*;
#(
    parameter int W = c_w_default
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] lo,
    output logic [W-1:0] hi,
    output logic         swap
);

    // Strict comparison so equal values never move (stable sort)
`ifdef ORDEN_DESCENDENTE_EN
    assign swap = (a < b);
`else
    assign swap = (a > b);
`endif

    assign lo = swap ? b : a;
    assign hi = swap ? a : b;

endmodule : comp_intercambio
`default_nettype wire

// File: rtl/control_ordenamiento.sv
`default_nettype none
// ============================================================================
//  Module      : control_ordenamiento
//  Description : Load/sort/display sequencer. Captures N operands (one per
//                rising edge of 'cargar'), bubble-sorts them in place with a
//                single time-shared compare-swap cell (one compare per
//                cycle), then shows one sorted value at a time, stepped by
//                rising edges of 'siguiente'.
//                Optional macro ORDEN_DESCENDENTE_EN selects descending order
//                (handled inside comp_intercambio).
//  Revision    : 1.0 - initial release
// ============================================================================
module control_ordenamiento
    import ordenamiento_pkg::*;
#(
    parameter int N = c_n_default,
    parameter int W = c_w_default
) (
    input  logic                 reloj,
    input  logic                 reset,
    input  logic [W-1:0]         entrada,
    input  logic                 cargar,
    input  logic                 siguiente,
    output logic [W-1:0]         salida,
    output logic [$clog2(N)-1:0] indice,
    output logic [$clog2(N):0]   cantidad,
    output logic                 ocupado,
    output logic                 listo
);

    localparam int              c_iw      = $clog2(N);
    localparam logic [c_iw-1:0] c_ult     = c_iw'(N - 1);
    localparam logic [c_iw-1:0] c_penult  = c_iw'(N - 2);
    localparam logic [c_iw-1:0] c_uno     = c_iw'(1);
    localparam logic [c_iw:0]   c_cnt_uno = (c_iw + 1)'(1);

    logic [1:0]      r_estado;
    logic [W-1:0]    r_banco [N];
    logic [c_iw-1:0] r_ptr;
    logic [c_iw-1:0] r_i;
    logic [c_iw-1:0] r_pasada;
    logic            r_swapflag;
    logic [c_iw-1:0] r_indice;
    logic [c_iw:0]   r_cantidad;
    logic            r_cargar_q;
    logic            r_siguiente_q;

    logic            w_pulso_cargar;
    logic            w_pulso_sig;
    logic            w_limpiar;
    logic [c_iw-1:0] w_i_sig;
    logic [W-1:0]    w_lo;
    logic [W-1:0]    w_hi;
    logic            w_swap;

    assign w_pulso_cargar = cargar & ~r_cargar_q;
    assign w_pulso_sig    = siguiente & ~r_siguiente_q;
    assign w_i_sig        = r_i + c_uno;
    // An illegal state encoding is treated exactly like a reset
    assign w_limpiar      = reset || (r_estado == c_invalido);

    comp_intercambio #(
        .W (W)
    ) u_comp (
        .a    (r_banco[r_i]),
        .b    (r_banco[w_i_sig]),
        .lo   (w_lo),
        .hi   (w_hi),
        .swap (w_swap)
    );

    // Strobe history; reset to 1 so a key held through reset is not an edge
    always_ff @(posedge reloj) begin
        if (reset) begin
            r_cargar_q    <= 1'b1;
            r_siguiente_q <= 1'b1;
        end else begin
            r_cargar_q    <= cargar;
            r_siguiente_q <= siguiente;
        end
    end

    // Sequencer: load, in-place bubble sort, display stepping
    always_ff @(posedge reloj) begin
        if (w_limpiar) begin
            r_estado   <= c_carga;
            r_ptr      <= '0;
            r_i        <= '0;
            r_pasada   <= '0;
            r_swapflag <= 1'b0;
            r_indice   <= '0;
            r_cantidad <= '0;
            for (int k = 0; k < N; k++) begin
                r_banco[k] <= '0;
            end
        end else begin
            case (r_estado)
                c_carga: begin
                    if (w_pulso_cargar) begin
                        r_banco[r_ptr] <= entrada;
                        r_cantidad     <= r_cantidad + c_cnt_uno;
                        if (r_ptr == c_ult) begin
                            r_ptr      <= '0;
                            r_i        <= '0;
                            r_pasada   <= '0;
                            r_swapflag <= 1'b0;
                            r_estado   <= c_ordena;
                        end else begin
                            r_ptr <= r_ptr + c_uno;
                        end
                    end
                end

                c_ordena: begin
                    // Pair is always written back; unchanged when no swap
                    r_banco[r_i]     <= w_lo;
                    r_banco[w_i_sig] <= w_hi;
                    if (r_i == c_penult) begin
                        // A clean pass (this compare included) means sorted;
                        // N-1 passes is the bubble-sort upper bound
                        if (!(r_swapflag || w_swap) || (r_pasada == c_penult)) begin
                            r_indice <= '0;
                            r_estado <= c_muestra;
                        end else begin
                            r_i        <= '0;
                            r_pasada   <= r_pasada + c_uno;
                            r_swapflag <= 1'b0;
                        end
                    end else begin
                        r_i        <= w_i_sig;
                        r_swapflag <= r_swapflag | w_swap;
                    end
                end

                c_muestra: begin
                    // A new load has priority and counts as the first operand
                    if (w_pulso_cargar) begin
                        r_banco[0] <= entrada;
                        r_ptr      <= c_uno;
                        r_cantidad <= c_cnt_uno;
                        r_indice   <= '0;
                        r_estado   <= c_carga;
                    end else if (w_pulso_sig) begin
                        r_indice <= (r_indice == c_ult) ? '0 : r_indice + c_uno;
                    end
                end

                default: begin
                    r_estado <= c_carga;
                end
            endcase
        end
    end

    assign ocupado  = (r_estado == c_ordena);
    assign listo    = (r_estado == c_muestra);
    assign indice   = r_indice;
    assign cantidad = r_cantidad;
    assign salida   = listo ? r_banco[r_indice] : '0;

endmodule : control_ordenamiento
`default_nettype wire

// File: tb/tb_control_ordenamiento.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_ordenamiento
//  Description : Directed self-checking bench for control_ordenamiento
//                (N=8, W=8). Honors ORDEN_DESCENDENTE_EN for expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_ordenamiento;

    localparam int N = 8;
    localparam int W = 8;

    logic         reloj;
    logic         reset;
    logic [W-1:0] entrada;
    logic         cargar;
    logic         siguiente;
    logic [W-1:0] salida;
    logic [2:0]   indice;
    logic [3:0]   cantidad;
    logic         ocupado;
    logic         listo;

    int           n_total;
    int           n_ok;
    int           ciclos;
    logic [W-1:0] vec [N];
    logic [W-1:0] esp [N];

    control_ordenamiento #(
        .N (N),
        .W (W)
    ) dut (
        .reloj     (reloj),
        .reset     (reset),
        .entrada   (entrada),
        .cargar    (cargar),
        .siguiente (siguiente),
        .salida    (salida),
        .indice    (indice),
        .cantidad  (cantidad),
        .ocupado   (ocupado),
        .listo     (listo)
    );

    // 100 MHz reference clock
    initial reloj = 1'b0;
    always #5 reloj = ~reloj;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_ok++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cargar_valor(input logic [W-1:0] v);
        entrada = v;
        cargar  = 1'b1;
        @(negedge reloj);
        cargar  = 1'b0;
        @(negedge reloj);
    endtask

    // Loads vec[0..7]; counts ocupado cycles until listo (bounded)
    task automatic cargar_banco();
        for (int k = 0; k < N - 1; k++) cargar_valor(vec[k]);
        entrada = vec[N-1];
        cargar  = 1'b1;
        @(negedge reloj);
        cargar  = 1'b0;
        ciclos  = 0;
        for (int t = 0; t < 200 && !listo; t++) begin
            if (ocupado) ciclos++;
            @(negedge reloj);
        end
    endtask

    task automatic pulso_sig();
        siguiente = 1'b1;
        @(negedge reloj);
        siguiente = 1'b0;
        @(negedge reloj);
    endtask

    // Steps through all 8 positions against esp[]; indice ends back at 0
    task automatic leer_todo(input string tag);
        for (int k = 0; k < N; k++) begin
            check($sformatf("%s_indice%0d", tag, k), 32'(indice), 32'(k));
            check($sformatf("%s_salida%0d", tag, k), 32'(salida), 32'(esp[k]));
            pulso_sig();
        end
    endtask

    initial begin
        n_total   = 0;
        n_ok      = 0;
        reset     = 1'b1;
        cargar    = 1'b1;   // held through reset release
        siguiente = 1'b0;
        entrada   = 8'h33;
        repeat (3) @(negedge reloj);
        check("rst_cantidad", 32'(cantidad), 0);
        check("rst_salida",   32'(salida),   0);
        check("rst_indice",   32'(indice),   0);
        check("rst_ocupado",  32'(ocupado),  0);
        check("rst_listo",    32'(listo),    0);
        reset = 1'b0;
        repeat (3) @(negedge reloj);
        check("held_key_no_load", 32'(cantidad), 0);
        cargar = 1'b0;
        @(negedge reloj);

        // Test 1: mixed vector
        vec = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4};
`ifdef ORDEN_DESCENDENTE_EN
        esp = '{8'd9, 8'd8, 8'd7, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
`else
        esp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd7, 8'd8, 8'd9};
`endif
        cargar_banco();
        check("t1_listo",      32'(listo), 1);
        check("t1_lat_le_49",  32'(ciclos <= 49), 1);
        check("t1_lat_ge_7",   32'(ciclos >= 7), 1);
        check("t1_cantidad",   32'(cantidad), 8);
        leer_todo("t1");

        // Test 2: presorted input sorts in a single pass
        for (int k = 0; k < N; k++) begin
`ifdef ORDEN_DESCENDENTE_EN
            vec[k] = 8'(N - 1 - k);
`else
            vec[k] = 8'(k);
`endif
            esp[k] = vec[k];
        end
        cargar_valor(vec[0]);
        check("t2_first_cantidad", 32'(cantidad), 1);
        check("t2_first_listo",    32'(listo), 0);
        for (int k = 1; k < N - 1; k++) cargar_valor(vec[k]);
        entrada = vec[N-1];
        cargar  = 1'b1;
        @(negedge reloj);
        cargar  = 1'b0;
        ciclos  = 0;
        for (int t = 0; t < 200 && !listo; t++) begin
            if (ocupado) ciclos++;
            @(negedge reloj);
        end
        check("t2_listo",   32'(listo), 1);
        check("t2_ocupado", 32'(ciclos), 7);
        leer_todo("t2");

        // Test 3a: all equal, no swaps
        for (int k = 0; k < N; k++) begin
            vec[k] = 8'hAA;
            esp[k] = 8'hAA;
        end
        cargar_banco();
        check("t3a_listo",   32'(listo), 1);
        check("t3a_ocupado", 32'(ciclos), 7);
        leer_todo("t3a");

        // Test 3b: extremes of the operand range
        vec = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0};
`ifdef ORDEN_DESCENDENTE_EN
        esp = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
`else
        esp = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255, 8'd255};
`endif
        cargar_banco();
        check("t3b_listo", 32'(listo), 1);
        leer_todo("t3b");

        // Test 5: display wrap, then simultaneous strobes
        repeat (7) pulso_sig();
        check("t5_indice7",  32'(indice), 7);
        check("t5_salida7",  32'(salida), 32'(esp[7]));
        pulso_sig();
        check("t5_wrap0",    32'(indice), 0);
        pulso_sig();
        check("t5_wrap1",    32'(indice), 1);
        entrada   = 8'h42;
        cargar    = 1'b1;
        siguiente = 1'b1;
        @(negedge reloj);
        cargar    = 1'b0;
        siguiente = 1'b0;
        @(negedge reloj);
        check("t5_both_listo",    32'(listo), 0);
        check("t5_both_cantidad", 32'(cantidad), 1);
        check("t5_both_indice",   32'(indice), 0);
        check("t5_both_salida",   32'(salida), 0);
        for (int k = 1; k < N - 1; k++) cargar_valor(8'(8'h50 + k - 1));
        entrada = 8'h56;
        cargar  = 1'b1;
        @(negedge reloj);
        cargar  = 1'b0;
        for (int t = 0; t < 200 && !listo; t++) @(negedge reloj);
        check("t5_reload_listo", 32'(listo), 1);
        check("t5_reload_cant",  32'(cantidad), 8);
`ifdef ORDEN_DESCENDENTE_EN
        esp = '{8'h56, 8'h55, 8'h54, 8'h53, 8'h52, 8'h51, 8'h50, 8'h42};
`else
        esp = '{8'h42, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56};
`endif
        leer_todo("t5r");

        // Test 4: reset in the middle of a sort
        for (int k = 0; k < N - 1; k++) cargar_valor(8'(20 + k * 3));
        entrada = 8'd90;
        cargar  = 1'b1;
        @(negedge reloj);
        cargar  = 1'b0;
        repeat (3) @(negedge reloj);
        check("t4_sorting", 32'(ocupado), 1);
        reset = 1'b1;
        @(negedge reloj);
        reset = 1'b0;
        check("t4_ocupado",  32'(ocupado), 0);
        check("t4_listo",    32'(listo), 0);
        check("t4_cantidad", 32'(cantidad), 0);
        check("t4_indice",   32'(indice), 0);
        check("t4_salida",   32'(salida), 0);
        @(negedge reloj);
        cargar_valor(8'd7);
        check("t4_restart_cantidad", 32'(cantidad), 1);

        $display("%0d/%0d checks passed", n_ok, n_total);
        $finish;
    end

endmodule : tb_control_ordenamiento
`default_nettype wire
